aq_gemac_tx_arb: RTL and testbench
==================================

AQ_GEMAC_TX_ARB -- requirements
Module: aq_gemac_tx_arb

Interface
REQ-001 SHALL have parameter IFG_LEN, default 12, giving idle byte-times enforced between frames (range 1..31).
REQ-002 SHALL have parameter MAX_LEN, default 1530, giving the maximum bytes passed per frame (range 64..2047).
REQ-003 SHALL have parameter START_TMO, default 16, giving the cycles allowed from grant to first valid byte (range 1..255).
REQ-004 SHALL have port tx_clk, input, 1, the single clock; all logic rising-edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL have port tx_en, input, 1; low blocks new grants, and any frame in progress completes.
REQ-007 SHALL have ports src0_req and src1_req, input, 1 each, meaning a frame is ready.
REQ-008 SHALL have ports src0_gnt and src1_gnt, output, 1 each, a one-cycle grant pulse.
REQ-009 SHALL have ports src0_valid and src1_valid, input, 1 each, byte valid; contiguous for a frame, and deassertion marks end of frame.
REQ-010 SHALL have ports src0_data and src1_data, input, 8 each, the frame byte.
REQ-011 SHALL have ports src0_err and src1_err, input, 1 each, a byte error flag.
REQ-012 SHALL have port bgmii_txd, output, 8, the byte toward the GMII output buffer.
REQ-013 SHALL have port bgmii_txe, output, 1, transmit enable toward the GMII output buffer.
REQ-014 SHALL have port bgmii_txer, output, 1, transmit error toward the GMII output buffer.
REQ-015 SHALL have port busy, output, 1; high in every state except IDLE.
REQ-016 SHALL have ports frame_done and frame_trunc, output, 1 each, one-cycle status pulses.

Function
REQ-017 SHALL implement the states IDLE, GRANT, PASS, DRAIN and IFG.
REQ-018 In IDLE with tx_en=1 and any req high, SHALL pick a source, pulse its gnt for one cycle and enter GRANT.
REQ-019 Arbitration SHALL be round-robin: with both requesting, the source not served last wins; after reset, src0 wins.
REQ-020 In GRANT, the first selected valid=1 SHALL enter PASS; if START_TMO cycles pass without valid, SHALL return to IDLE with no output, and the pointer advances.
REQ-021 In PASS, bgmii_txd/txe/txer SHALL be registered copies of the selected data/valid/err, with exactly 1-cycle latency; the unselected source is ignored.
REQ-022 SHALL count bytes passed in an 11-bit counter; count == MAX_LEN while valid is still 1 SHALL drive that byte out with txer=1, pulse frame_trunc, and enter DRAIN.
REQ-023 In DRAIN, txe=0 and txer=0; source bytes are discarded until valid=0, then the block enters IFG.
REQ-024 In PASS, valid=0 SHALL drive txe=0 on the next cycle, pulse frame_done and enter IFG.
REQ-025 IFG SHALL hold txe=0 for exactly IFG_LEN cycles, counted from the first txe=0 cycle, then enter IDLE; a req seen during IFG is granted on the first IDLE cycle.
REQ-026 Outside PASS, bgmii_txd SHALL be 8'h00 and txe and txer SHALL be 0.
REQ-027 A req dropped in GRANT SHALL have no effect; only valid or the timeout ends GRANT.
REQ-028 tx_en falling mid-frame SHALL NOT cut the frame.
REQ-029 Both gnt outputs SHALL never be high in the same cycle.

Reset
REQ-030 rst high SHALL immediately force state IDLE and the pointer to favour src0.
REQ-031 rst high SHALL force all outputs to 0 and clear all counters.
REQ-032 rst asserted mid-frame SHALL drop txe at once, with no txer or status pulse.
REQ-033 Operation SHALL resume on the first tx_clk edge after rst falls.

Structure
REQ-034 The state enum and the default values of IFG_LEN, MAX_LEN and START_TMO SHALL live in the shared package aq_gemac_pkg.
REQ-035 The two-requester round-robin picker SHALL be the sub-module aq_gemac_rr_arb2, with inputs req[1:0] and advance, and output onehot grant.

Verification
REQ-036 Single frame: src0 sends 60 bytes 0x01..0x3C -> txe high for 60 cycles, starting 1 cycle after the first valid; data matches; one frame_done pulse; 12 idle cycles follow.
REQ-037 Contention: both req held, each sending 64-byte frames -> grants alternate src0, src1, src0; the gap between txe low and the next txe high is at least 12 cycles.
REQ-038 Oversize: src1 sends 1600 bytes -> txe covers 1530 bytes; byte 1530 has txer=1; frame_trunc pulses; bytes 1531..1600 are discarded; the IFG starts after src1 valid drops.
REQ-039 Timeout: src0 granted and never asserts valid -> back to IDLE after 16 cycles with txe always 0; a pending src1 is granted next.
REQ-040 Gating: tx_en=0 with req high -> no gnt; tx_en dropped mid-frame -> the frame completes.
REQ-041 Reset mid-frame: rst pulsed at byte 30 -> txe drops asynchronously; after release, src0 wins arbitration.

Source files
------------

// File: rtl/aq_gemac_pkg.sv
// aq_gemac_pkg: shared state encoding and parameter defaults for the GEMAC transmit arbiter.
package aq_gemac_pkg;

    typedef enum logic [2:0] {IDLE, GRANT, PASS, DRAIN, IFG} state_t;

    localparam int IFG_LEN_DEF   = 12;
    localparam int MAX_LEN_DEF   = 1530;
    localparam int START_TMO_DEF = 16;

endpackage

// File: rtl/aq_gemac_rr_arb2.sv
// aq_gemac_rr_arb2: two-requester round-robin picker; the source not served last wins a tie.
module aq_gemac_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last;

    always_comb grant = {req[1] & (~req[0] | ~last), req[0] & (~req[1] | last)};

    // last starts at src1 so src0 wins the first tie after reset
    always_ff @(posedge clk or posedge rst)
        if (rst)
            last <= 1'b1;
        else if (advance && |grant)
            last <= grant[1];

endmodule

// File: rtl/aq_gemac_tx_arb.sv
// aq_gemac_tx_arb: arbitrates two frame sources onto one GMII byte stream,
// enforcing start timeout, maximum frame length and inter-frame gap.
module aq_gemac_tx_arb
    import aq_gemac_pkg::*;
#(
    parameter int IFG_LEN   = IFG_LEN_DEF,
    parameter int MAX_LEN   = MAX_LEN_DEF,
    parameter int START_TMO = START_TMO_DEF
) (
    input  logic       tx_clk,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       src0_req,
    input  logic       src1_req,
    output logic       src0_gnt,
    output logic       src1_gnt,
    input  logic       src0_valid,
    input  logic       src1_valid,
    input  logic [7:0] src0_data,
    input  logic [7:0] src1_data,
    input  logic       src0_err,
    input  logic       src1_err,
    output logic [7:0] bgmii_txd,
    output logic       bgmii_txe,
    output logic       bgmii_txer,
    output logic       busy,
    output logic       frame_done,
    output logic       frame_trunc
);

    state_t      state, n_state;
    logic        sel, n_sel;
    logic [10:0] cnt, n_cnt;
    logic [7:0]  tmr, n_tmr;
    logic [7:0]  n_txd;
    logic        n_txe, n_txer, n_done, n_trunc;
    logic [1:0]  grant;
    logic        start, v, e, last_byte;
    logic [7:0]  d;

    // grant is combinational so the pulse lands in the IDLE cycle itself
    assign start     = (state == IDLE) & tx_en & ~rst;
    assign src0_gnt  = start & grant[0];
    assign src1_gnt  = start & grant[1];
    assign busy      = state != IDLE;
    assign v         = sel ? src1_valid : src0_valid;
    assign d         = sel ? src1_data : src0_data;
    assign e         = sel ? src1_err : src0_err;
    assign last_byte = cnt + 11'd1 == 11'(MAX_LEN);

    aq_gemac_rr_arb2 u_rr (
        .clk    (tx_clk),
        .rst    (rst),
        .req    ({src1_req, src0_req}),
        .advance(start),
        .grant  (grant)
    );

    always_comb begin
        n_state = state;
        n_sel   = sel;
        n_cnt   = cnt;
        n_tmr   = tmr;
        n_txd   = 8'h00;
        n_txe   = 1'b0;
        n_txer  = 1'b0;
        n_done  = 1'b0;
        n_trunc = 1'b0;
        case (state)
            IDLE:
                if (start && |grant) begin
                    n_state = GRANT;
                    n_sel   = grant[1];
                    n_tmr   = 8'd0;
                end
            GRANT:
                if (v) begin
                    n_state = PASS;
                    n_txd   = d;
                    n_txe   = 1'b1;
                    n_txer  = e;
                    n_cnt   = 11'd1;
                end else if (tmr == 8'(START_TMO - 1))
                    n_state = IDLE;
                else
                    n_tmr = tmr + 8'd1;
            PASS:
                if (v) begin
                    n_txd   = d;
                    n_txe   = 1'b1;
                    n_txer  = e | last_byte;
                    n_trunc = last_byte;
                    n_cnt   = cnt + 11'd1;
                    n_state = last_byte ? DRAIN : PASS;
                end else begin
                    n_done  = 1'b1;
                    n_tmr   = 8'd0;
                    n_state = IFG;
                end
            DRAIN:
                if (!v) begin
                    n_tmr   = 8'd0;
                    n_state = IFG;
                end
            default:
                if (tmr == 8'(IFG_LEN - 1)) begin
                    n_state = IDLE;
                    n_cnt   = 11'd0;
                end else
                    n_tmr = tmr + 8'd1;
        endcase
    end

    always_ff @(posedge tx_clk or posedge rst)
        if (rst) begin
            state       <= IDLE;
            sel         <= 1'b0;
            cnt         <= 11'd0;
            tmr         <= 8'd0;
            bgmii_txd   <= 8'h00;
            bgmii_txe   <= 1'b0;
            bgmii_txer  <= 1'b0;
            frame_done  <= 1'b0;
            frame_trunc <= 1'b0;
        end else begin
            state       <= n_state;
            sel         <= n_sel;
            cnt         <= n_cnt;
            tmr         <= n_tmr;
            bgmii_txd   <= n_txd;
            bgmii_txe   <= n_txe;
            bgmii_txer  <= n_txer;
            frame_done  <= n_done;
            frame_trunc <= n_trunc;
        end

endmodule

// File: tb/tb_aq_gemac_tx_arb.sv
// tb_aq_gemac_tx_arb: directed vectors and hand-written sequences for the transmit arbiter.
module tb_aq_gemac_tx_arb;

    logic       tx_clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_en = 1'b0;
    logic       src0_req = 1'b0, src1_req = 1'b0;
    logic       src0_valid = 1'b0, src1_valid = 1'b0;
    logic [7:0] src0_data = 8'h00, src1_data = 8'h00;
    logic       src0_err = 1'b0, src1_err = 1'b0;
    logic       src0_gnt, src1_gnt;
    logic [7:0] bgmii_txd;
    logic       bgmii_txe, bgmii_txer, busy, frame_done, frame_trunc;
    logic       mon_clr = 1'b1;
    logic [15:0] obs;

    int tests = 0;
    int fails = 0;

    always #5 tx_clk = ~tx_clk;

    aq_gemac_tx_arb dut (
        .tx_clk     (tx_clk),
        .rst        (rst),
        .tx_en      (tx_en),
        .src0_req   (src0_req),
        .src1_req   (src1_req),
        .src0_gnt   (src0_gnt),
        .src1_gnt   (src1_gnt),
        .src0_valid (src0_valid),
        .src1_valid (src1_valid),
        .src0_data  (src0_data),
        .src1_data  (src1_data),
        .src0_err   (src0_err),
        .src1_err   (src1_err),
        .bgmii_txd  (bgmii_txd),
        .bgmii_txe  (bgmii_txe),
        .bgmii_txer (bgmii_txer),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_trunc(frame_trunc)
    );

    assign obs = {src1_gnt, src0_gnt, bgmii_txe, bgmii_txer, busy, frame_done, frame_trunc, 1'b0, bgmii_txd};

    // output monitor, sampled on the falling edge
    int         txe_n, done_n, trunc_n, txer_n, txer_pos, both_n, gnt_n, low_run, min_gap;
    logic       seen;
    logic [7:0] cap [0:2047];

    always @(negedge tx_clk) begin
        if (mon_clr) begin
            txe_n    <= 0;
            done_n   <= 0;
            trunc_n  <= 0;
            txer_n   <= 0;
            txer_pos <= 0;
            both_n   <= 0;
            gnt_n    <= 0;
            low_run  <= 0;
            min_gap  <= 1000000;
            seen     <= 1'b0;
        end else begin
            if (bgmii_txe) begin
                if (txe_n < 2048) cap[txe_n[10:0]] <= bgmii_txd;
                txe_n <= txe_n + 1;
                if (bgmii_txer) begin
                    txer_n   <= txer_n + 1;
                    txer_pos <= txe_n + 1;
                end
                if (seen && low_run > 0 && low_run < min_gap) min_gap <= low_run;
                low_run <= 0;
                seen    <= 1'b1;
            end else if (seen)
                low_run <= low_run + 1;
            done_n  <= done_n + int'(frame_done);
            trunc_n <= trunc_n + int'(frame_trunc);
            gnt_n   <= gnt_n + int'(src0_gnt) + int'(src1_gnt);
            both_n  <= both_n + int'(src0_gnt & src1_gnt);
        end
    end

    typedef struct {
        logic        en, r0, r1, v0, e0, v1;
        logic [7:0]  d0, d1;
        logic [15:0] exp;
    } vec_t;

    vec_t vt [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge tx_clk);
        #1;
    endtask

    task automatic drive(input int s, input logic v, input logic [7:0] d, input logic e);
        if (s == 0) begin
            src0_valid = v;
            src0_data  = d;
            src0_err   = e;
        end else begin
            src1_valid = v;
            src1_data  = d;
            src1_err   = e;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        mon_clr  = 1'b1;
        tx_en    = 1'b0;
        src0_req = 1'b0;
        src1_req = 1'b0;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        tick();
        tick();
        rst     = 1'b0;
        mon_clr = 1'b0;
    endtask

    task automatic wait_gnt(output int s);
        s = -1;
        #1;
        for (int n = 0; n < 200 && s < 0; n++)
            if (src0_gnt) s = 0;
            else if (src1_gnt) s = 1;
            else tick();
        if (s < 0) check("gnt_wait", 32'd0, 32'd1);
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            tick();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int s, n, bad;
        int got [3];
        vt[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h4000};
        vt[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hAA, 8'h00, 16'h0800};
        vt[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hBB, 8'h00, 16'h28AA};
        vt[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hCC, 8'h55, 16'h38BB};
        vt[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h28CC};
        vt[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0C00};
        vt[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0800};

        // outputs must be low while reset is held, even with a request pending
        tx_en    = 1'b1;
        src0_req = 1'b1;
        #1;
        check("reset_outputs", 32'(obs), 32'h0);

        // short frame with an error byte, the other source chattering alongside
        do_reset();
        for (int i = 0; i < 7; i++) begin
            tx_en      = vt[i].en;
            src0_req   = vt[i].r0;
            src1_req   = vt[i].r1;
            src0_valid = vt[i].v0;
            src0_data  = vt[i].d0;
            src0_err   = vt[i].e0;
            src1_valid = vt[i].v1;
            src1_data  = vt[i].d1;
            src1_err   = 1'b0;
            #1;
            check($sformatf("vec%0d", i), 32'(obs), 32'(vt[i].exp));
            tick();
        end

        // single 60-byte frame from src0
        do_reset();
        tx_en    = 1'b1;
        src0_req = 1'b1;
        wait_gnt(s);
        check("single_gnt_src", s, 0);
        tick();
        src0_req = 1'b0;
        drive(0, 1'b1, 8'h01, 1'b0);
        #1;
        check("single_lat_pre", 32'(bgmii_txe), 32'd0);
        tick();
        check("single_lat_first", {bgmii_txe, bgmii_txd}, {1'b1, 8'h01});
        for (int j = 2; j <= 60; j++) begin
            drive(0, 1'b1, 8'(j), 1'b0);
            tick();
        end
        drive(0, 1'b0, 8'h00, 1'b0);
        tick();
        src1_req = 1'b1;
        busy_len(n);
        check("single_ifg_len", n, 12);
        #1;
        check("single_ifg_req_gnt", {src1_gnt, src0_gnt}, 2'b10);
        bad = 0;
        for (int i = 0; i < 60; i++)
            if (cap[i] !== 8'(i + 1)) bad++;
        check("single_data", bad, 0);
        check("single_txe_cycles", txe_n, 60);
        check("single_done", done_n, 1);
        check("single_no_trunc_err", trunc_n + txer_n, 0);

        // contention: both requests held, 64-byte frames
        do_reset();
        tx_en    = 1'b1;
        src0_req = 1'b1;
        src1_req = 1'b1;
        for (int f = 0; f < 3; f++) begin
            wait_gnt(s);
            got[f] = s;
            tick();
            for (int j = 1; j <= 64; j++) begin
                drive(s, 1'b1, 8'(j), 1'b0);
                tick();
            end
            drive(s, 1'b0, 8'h00, 1'b0);
        end
        src0_req = 1'b0;
        src1_req = 1'b0;
        repeat (20) tick();
        check("rr_order", {got[0][1:0], got[1][1:0], got[2][1:0]}, 6'b00_01_00);
        check("rr_txe_cycles", txe_n, 192);
        check("rr_done", done_n, 3);
        check("rr_min_gap_ge12", 32'(min_gap >= 12), 32'd1);
        check("rr_never_both", both_n, 0);

        // oversize frame from src1
        do_reset();
        tx_en    = 1'b1;
        src1_req = 1'b1;
        wait_gnt(s);
        check("over_gnt_src", s, 1);
        tick();
        src1_req = 1'b0;
        for (int j = 1; j <= 1600; j++) begin
            drive(1, 1'b1, 8'(j), 1'b0);
            tick();
        end
        drive(1, 1'b0, 8'h00, 1'b0);
        busy_len(n);
        check("over_drain_ifg_len", n, 13);
        check("over_txe_cycles", txe_n, 1530);
        check("over_txer_once", txer_n, 1);
        check("over_txer_pos", txer_pos, 1530);
        check("over_trunc", trunc_n, 1);
        check("over_no_done", done_n, 0);
        bad = 0;
        for (int i = 0; i < 1530; i++)
            if (cap[i] !== 8'(i + 1)) bad++;
        check("over_data", bad, 0);

        // start timeout with src1 pending
        do_reset();
        tx_en    = 1'b1;
        src0_req = 1'b1;
        wait_gnt(s);
        check("tmo_gnt_src", s, 0);
        tick();
        src0_req = 1'b0;
        src1_req = 1'b1;
        busy_len(n);
        check("tmo_len", n, 16);
        #1;
        check("tmo_next_gnt", {src1_gnt, src0_gnt}, 2'b10);
        check("tmo_no_txe", txe_n, 0);

        // tx_en gating
        do_reset();
        tx_en    = 1'b0;
        src0_req = 1'b1;
        repeat (5) tick();
        check("gate_no_gnt", gnt_n, 0);
        check("gate_not_busy", 32'(busy), 32'd0);
        tx_en = 1'b1;
        wait_gnt(s);
        check("gate_gnt_src", s, 0);
        tick();
        src0_req = 1'b0;
        for (int j = 1; j <= 10; j++) begin
            if (j == 3) tx_en = 1'b0;
            drive(0, 1'b1, 8'(j), 1'b0);
            tick();
        end
        drive(0, 1'b0, 8'h00, 1'b0);
        repeat (15) tick();
        check("gate_frame_len", txe_n, 10);
        check("gate_frame_done", done_n, 1);

        // reset mid-frame at byte 30
        do_reset();
        tx_en    = 1'b1;
        src0_req = 1'b1;
        wait_gnt(s);
        tick();
        src0_req = 1'b0;
        for (int j = 1; j <= 30; j++) begin
            drive(0, 1'b1, 8'(j), 1'b0);
            tick();
        end
        check("rst_pre_txe", {bgmii_txe, bgmii_txd}, {1'b1, 8'd30});
        rst = 1'b1;
        #1;
        check("rst_async_outputs", 32'(obs), 32'h0);
        drive(0, 1'b0, 8'h00, 1'b0);
        src0_req = 1'b1;
        src1_req = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("rst_src0_wins", {src1_gnt, src0_gnt}, 2'b01);
        check("rst_no_status", done_n + trunc_n + txer_n, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
